// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_ctrl
// Description : First-word-fall-through FIFO controller for a one-clock
//               dual-port BRAM, with a 2-entry head/skid output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_ctrl #(
    parameter int ADDR = 10,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [DATA-1:0] wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [DATA-1:0] rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [ADDR+1:0] level,
    output logic            empty,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_waddr,
    output logic [DATA-1:0] ram_wdata,
    output logic [ADDR-1:0] ram_raddr,
    input  logic [DATA-1:0] ram_rdata
);

    localparam logic [ADDR:0] c_DEPTH = {1'b1, {ADDR{1'b0}}};

    logic [ADDR-1:0] r_wptr;
    logic [ADDR-1:0] r_rptr;
    logic [ADDR:0]   r_occ;
    logic            r_inflight;
    logic [DATA-1:0] r_head;
    logic [DATA-1:0] r_skid;
    logic [1:0]      r_ocnt;
    logic [ADDR+1:0] r_level;

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic [1:0]      w_pend;
    logic [ADDR:0]   w_occ_n;
    logic [DATA-1:0] w_head_n;
    logic [DATA-1:0] w_skid_n;
    logic [1:0]      w_ocnt_n;
    logic [ADDR+1:0] w_level_n;

    assign wr_ready = (r_occ != c_DEPTH) & ~reset & ~flush;
    assign w_push   = wr_valid & wr_ready;
    assign rd_valid = (r_ocnt != 2'd0);
    assign w_pop    = rd_valid & rd_ready;
    assign w_pend   = r_ocnt + {1'b0, r_inflight};

    // While streaming (word in flight, head being popped) the captured word
    // takes the popped head's slot, so a new read can be issued without
    // overrunning the two-entry stage.
    assign w_issue  = (r_occ != '0) & ~flush &
                      ((w_pend < 2'd2) | (r_inflight & w_pop));

    assign w_occ_n   = r_occ + {{ADDR{1'b0}}, w_push} - {{ADDR{1'b0}}, w_issue};
    assign w_level_n = {1'b0, w_occ_n} + {{(ADDR+1){1'b0}}, w_issue}
                     + {{ADDR{1'b0}}, w_ocnt_n};

    always_comb begin
        w_head_n = r_head;
        w_skid_n = r_skid;
        w_ocnt_n = r_ocnt;
        case ({r_inflight, w_pop})
            2'b10: begin
                if (r_ocnt == 2'd0) w_head_n = ram_rdata;
                else                w_skid_n = ram_rdata;
                w_ocnt_n = r_ocnt + 2'd1;
            end
            2'b01: begin
                w_head_n = r_skid;
                w_ocnt_n = r_ocnt - 2'd1;
            end
            2'b11: begin
                if (r_ocnt == 2'd1) begin
                    w_head_n = ram_rdata;
                end else begin
                    w_head_n = r_skid;
                    w_skid_n = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset | flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
            r_ocnt     <= 2'd0;
            r_level    <= '0;
        end else begin
            if (w_push)  r_wptr <= r_wptr + 1'b1;
            if (w_issue) r_rptr <= r_rptr + 1'b1;
            r_occ      <= w_occ_n;
            r_inflight <= w_issue;
            r_head     <= w_head_n;
            r_skid     <= w_skid_n;
            r_ocnt     <= w_ocnt_n;
            r_level    <= w_level_n;
        end
    end

    assign rd_data   = r_head;
    assign level     = r_level;
    assign empty     = (r_level == '0);
    assign ram_we    = w_push;
    assign ram_waddr = r_wptr;
    assign ram_wdata = wr_data;
    assign ram_raddr = r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_fifo_ctrl
// Description : Directed and randomised self-checking bench for bram_fifo_ctrl
//               with a behavioural one-clock BRAM and a reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo_ctrl;

    localparam int ADDR  = 4;
    localparam int DATA  = 8;
    localparam int DEPTH = 1 << ADDR;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [DATA-1:0] wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [DATA-1:0] rd_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [ADDR+1:0] level;
    logic            empty;
    logic            ram_we;
    logic [ADDR-1:0] ram_waddr;
    logic [DATA-1:0] ram_wdata;
    logic [ADDR-1:0] ram_raddr;
    logic [DATA-1:0] ram_rdata;

    logic [DATA-1:0] mem [DEPTH];
    logic [DATA-1:0] model [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int first_pop;
    int last_pop;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .empty     (empty),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Registered-address block RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: account for handshakes, advance past the edge, check level.
    task automatic cycle();
        logic            pushed;
        logic            popped;
        logic [DATA-1:0] exp_w;
        #1;
        pushed = wr_valid & wr_ready;
        popped = rd_valid & rd_ready;
        if (popped) begin
            n_pop++;
            if (model.size() == 0) begin
                check("pop_extra", 32'(rd_valid), 0);
            end else begin
                exp_w = model.pop_front();
                check("rd_data", 32'(rd_data), 32'(exp_w));
            end
        end
        if (reset | flush) model.delete();
        else if (pushed) begin
            model.push_back(wr_data);
            n_push++;
        end
        @(posedge clk);
        #1;
        n_cyc++;
        check("level", 32'(level), model.size());
        check("empty", 32'(empty), 32'(level == 0));
    endtask

    task automatic note_pop();
        if (rd_valid && rd_ready) begin
            if (first_pop < 0) first_pop = n_cyc;
            last_pop = n_cyc;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && model.size() != 0; i++) cycle();
        check("drain_done", model.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !rd_valid; i++) cycle();
        check("wait_valid", 32'(rd_valid), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        // Reset
        #1;
        check("wr_ready_in_reset", 32'(wr_ready), 0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_raddr", 32'(ram_raddr), 0);

        // Three back-to-back writes, consumer stalled
        wr_valid = 1'b1; wr_data = 'h11;
        cycle();
        check("t1_valid_e0", 32'(rd_valid), 0);
        wr_data = 'h22;
        cycle();
        check("t1_valid_e1", 32'(rd_valid), 0);
        wr_data = 'h33;
        cycle();
        wr_valid = 1'b0;
        check("t1_valid_e2", 32'(rd_valid), 1);
        check("t1_head", 32'(rd_data), 'h11);
        cycle();
        check("t1_level", 32'(level), 3);
        check("t1_raddr", 32'(ram_raddr), 2);
        check("t1_head_hold", 32'(rd_data), 'h11);
        rd_ready = 1'b1;
        drain(20);
        rd_ready = 1'b0;

        // Continuous stream with pointer wrap
        first_pop = -1; last_pop = -1; n_pop = 0;
        rd_ready = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < DEPTH + 6; i++) begin
            wr_data = 8'(i);
            note_pop();
            cycle();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 40 && model.size() != 0; i++) begin
            note_pop();
            cycle();
        end
        check("stream_pops", n_pop, DEPTH + 6);
        check("stream_span", last_pop - first_pop + 1, DEPTH + 6);
        check("stream_empty", model.size(), 0);
        rd_ready = 1'b0;

        // Fill to full, then a single pop reopens exactly one write slot
        n_push = 0; wr_valid = 1'b1;
        for (int i = 0; i < DEPTH + 10 && wr_ready; i++) begin
            wr_data = 8'(32'h40 + i);
            cycle();
        end
        check("fill_count", n_push, DEPTH + 2);
        check("fill_level", 32'(level), DEPTH + 2);
        check("fill_wr_ready", 32'(wr_ready), 0);
        wr_data = 'hE1;
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check("fill_pop_p1", 32'(wr_ready), 0);
        cycle();
        check("fill_pop_p2", 32'(wr_ready), 1);
        cycle();
        check("fill_pop_p3", 32'(wr_ready), 0);
        check("fill_one_more", n_push, DEPTH + 3);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        drain(80);
        rd_ready = 1'b0;

        // Flush with a word in flight and the head occupied
        wr_valid = 1'b1;
        wr_data = 'h31; cycle();
        wr_data = 'h32; cycle();
        wr_data = 'h33; cycle();
        check("fl_pre_level", 32'(level), 3);
        check("fl_pre_valid", 32'(rd_valid), 1);
        wr_data = 'h99; flush = 1'b1;
        #1;
        check("fl_ram_we", 32'(ram_we), 0);
        check("fl_wr_ready", 32'(wr_ready), 0);
        cycle();
        flush = 1'b0; wr_valid = 1'b0;
        check("fl_rd_valid", 32'(rd_valid), 0);
        check("fl_level", 32'(level), 0);
        wr_valid = 1'b1; wr_data = 'hA5;
        cycle();
        wr_valid = 1'b0;
        wait_valid(10);
        check("fl_first_word", 32'(rd_data), 'hA5);
        rd_ready = 1'b1;
        drain(10);
        rd_ready = 1'b0;

        // Write into empty RAM while popping the last held word
        wr_valid = 1'b1; wr_data = 'h77;
        cycle();
        wr_valid = 1'b0;
        wait_valid(10);
        cycle();
        cycle();
        wr_valid = 1'b1; wr_data = 'h5C; rd_ready = 1'b1;
        cycle();
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("ew_gap1", 32'(rd_valid), 0);
        cycle();
        check("ew_gap2", 32'(rd_valid), 0);
        cycle();
        check("ew_valid", 32'(rd_valid), 1);
        check("ew_data", 32'(rd_data), 'h5C);
        rd_ready = 1'b1;
        drain(10);

        // Random traffic against the reference queue
        n_push = 0;
        for (int g = 0; g < 70000 && n_push < 10000; g++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            cycle();
            check("rand_level_max", 32'(level <= DEPTH + 2), 1);
        end
        check("rand_words", n_push, 10000);
        wr_valid = 1'b0; rd_ready = 1'b1;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
